// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 memory interface.
//   WORD_W              - datapath / memory word width
//   DEFAULT_ACK_TIMEOUT - default cycles to wait for mem_ack before aborting
//   mem_state_t         - handshake FSM states
package lc3_pkg;

    localparam int unsigned WORD_W              = 16;
    localparam int unsigned DEFAULT_ACK_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/lc3_mem_if_if.sv
// lc3_mem_if_if: memory-side request/acknowledge bus.
//   master : drives mem_req, mem_we, mem_addr, mem_wdata; samples mem_rdata, mem_ack
//   slave  : the memory model side of the same signals
interface lc3_mem_if_if;
    import lc3_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/lc3_mem_fsm.sv
// lc3_mem_fsm: handshake FSM and ack timeout counter.
//   clk, rst      - clock, synchronous active-high reset
//   mio_en, r_w   - access request and type (1=write)
//   mem_ack       - completion from memory
//   mar, mdr      - address / write data captured at access launch
//   mem_req, mem_we, mem_addr, mem_wdata - memory request outputs
//   ready         - DONE flag (R)
//   mem_err       - sticky timeout flag
//   idle          - FSM in IDLE (gates MAR/MDR loads)
//   mdr_ld_rdata  - load MDR from mem_rdata this edge (read ack)
//   mdr_ld_zero   - clear MDR this edge (read timeout)
module lc3_mem_fsm
    import lc3_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mio_en,
    input  logic              r_w,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mar,
    input  logic [WORD_W-1:0] mdr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              ready,
    output logic              mem_err,
    output logic              idle,
    output logic              mdr_ld_rdata,
    output logic              mdr_ld_zero
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             launch;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (launch) begin
                mem_addr  <= mar;
                mem_wdata <= mdr;
                mem_we    <= r_w;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        launch       = 1'b0;
        timeout      = 1'b0;
        mdr_ld_rdata = 1'b0;
        mdr_ld_zero  = 1'b0;
        case (state)
            IDLE: begin
                if (mio_en) begin
                    state_n = REQ;
                    cnt_n   = '0;
                    launch  = 1'b1;
                end
            end
            REQ: begin
                // cnt counts completed wait cycles; ack wins over a same-cycle timeout
                if (mem_ack) begin
                    state_n      = DONE;
                    mdr_ld_rdata = !mem_we;
                end else if (cnt == LAST) begin
                    state_n     = DONE;
                    timeout     = 1'b1;
                    mdr_ld_zero = !mem_we;
                end else if (cnt < LAST) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                if (!mio_en) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_req = (state == REQ);
    assign ready   = (state == DONE);
    assign idle    = (state == IDLE);

endmodule

// File: rtl/lc3_mem_if.sv
// lc3_mem_if: LC-3 MAR/MDR memory interface.
//   clk, rst        - clock, synchronous active-high reset
//   bus_in          - value on the datapath main bus
//   LD_MAR, LD_MDR  - register loads (honoured only in IDLE)
//   MIO_EN, R_W     - memory access request and type (1=write)
//   GateMDR         - drive MDR onto main_bus
//   main_bus        - MDR when GateMDR=1, otherwise high impedance
//   R               - ready flag to the control FSM
//   mem_err         - sticky ack timeout flag
//   mem             - memory request/ack bus (master side)
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] bus_in,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MIO_EN,
    input  logic              R_W,
    input  logic              GateMDR,
    output logic [WORD_W-1:0] main_bus,
    output logic              R,
    output logic              mem_err,
    lc3_mem_if_if.master      mem
);

    logic [WORD_W-1:0] mar;
    logic [WORD_W-1:0] mdr;
    logic              idle;
    logic              mdr_ld_rdata;
    logic              mdr_ld_zero;

    lc3_mem_fsm #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .mio_en       (MIO_EN),
        .r_w          (R_W),
        .mem_ack      (mem.mem_ack),
        .mar          (mar),
        .mdr          (mdr),
        .mem_req      (mem.mem_req),
        .mem_we       (mem.mem_we),
        .mem_addr     (mem.mem_addr),
        .mem_wdata    (mem.mem_wdata),
        .ready        (R),
        .mem_err      (mem_err),
        .idle         (idle),
        .mdr_ld_rdata (mdr_ld_rdata),
        .mdr_ld_zero  (mdr_ld_zero)
    );

    // The FSM captures pre-edge MAR/MDR at launch, so loads in the same
    // IDLE cycle as MIO_EN still take effect without disturbing the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (idle && LD_MAR) begin
                mar <= bus_in;
            end
            if (mdr_ld_rdata) begin
                mdr <= mem.mem_rdata;
            end else if (mdr_ld_zero) begin
                mdr <= '0;
            end else if (idle && LD_MDR) begin
                mdr <= bus_in;
            end
        end
    end

    assign main_bus = GateMDR ? mdr : 'z;

endmodule

// File: doc/lc3_mem_if.md
LC3_MEM_IF -- requirements
Module: lc3_mem_if

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum number of cycles spent waiting for mem_ack before abort.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 bus_in  input  16  SHALL carry the value currently driven on the datapath main bus.
REQ-005 LD_MAR  input  1  SHALL load MAR from bus_in.
REQ-006 LD_MDR  input  1  SHALL load MDR, from bus_in when MIO_EN=0.
REQ-007 MIO_EN  input  1  SHALL request a memory access.
REQ-008 R_W  input  1  SHALL select the access type: 1=write, 0=read.
REQ-009 GateMDR  input  1  SHALL enable driving MDR onto the bus.
REQ-010 main_bus  output  16  SHALL carry MDR when GateMDR=1, else 16'bZ.
REQ-011 R  output  1  SHALL be the ready flag to the control FSM.
REQ-012 mem_err  output  1  SHALL be the sticky timeout flag.
REQ-013 mem_req, mem_we  output  1 each  SHALL be the memory request and write strobe.
REQ-014 mem_addr, mem_wdata  output  16 each  SHALL carry the memory address and write data.
REQ-015 mem_rdata  input  16, mem_ack  input  1  SHALL carry the memory read data and completion.

Function
REQ-016 FSM SHALL have states IDLE, REQ, DONE.
REQ-017 IDLE: LD_MAR SHALL set MAR<=bus_in; LD_MDR with MIO_EN=0 SHALL set MDR<=bus_in; both loads effective the next cycle.
REQ-018 IDLE with MIO_EN=1 SHALL go to REQ, latching mem_addr<=MAR, mem_wdata<=MDR and mem_we<=R_W; mem_req=1 starts the following cycle.
REQ-019 REQ SHALL hold mem_req, mem_addr, mem_we and mem_wdata stable until mem_ack=1 or timeout.
REQ-020 REQ with mem_ack=1 SHALL go to DONE and drop mem_req the next cycle; on a read, MDR<=mem_rdata in the same edge.
REQ-021 Timeout: REQ lasting ACK_TIMEOUT cycles without mem_ack SHALL go to DONE, set mem_err=1 and, on a read, load MDR<=16'h0000.
REQ-022 DONE SHALL assert R=1 and return to IDLE on the first cycle MIO_EN=0; DONE SHALL NOT reissue an access while MIO_EN stays high.
REQ-023 LD_MAR and LD_MDR outside IDLE SHALL be ignored; MAR and MDR keep their values except per REQ-020/021.
REQ-024 In IDLE, LD_MAR, LD_MDR and MIO_EN all asserted in one cycle SHALL start the access with the pre-edge MAR and MDR; the loads also take effect.
REQ-025 mem_ack seen in IDLE or DONE SHALL be ignored.
REQ-026 Read latency SHALL be as follows: MIO_EN in cycle 0, mem_req in cycle 1, ack in cycle k>=1, R=1 and MDR valid in cycle k+1.
REQ-027 Timeout counter SHALL clear on entry to REQ and SHALL saturate; it SHALL NOT wrap.
REQ-028 main_bus SHALL be combinational from GateMDR and MDR, independent of FSM state.

Reset
REQ-029 rst=1 SHALL, at the next edge, set state=IDLE, MAR=0, MDR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, R=0, mem_err=0 and the timeout counter to 0.
REQ-030 Reset mid-access SHALL drop mem_req the next cycle with no MDR update; mem_ack arriving after reset SHALL be ignored.
REQ-031 rst SHALL take priority over all loads and transitions.

Structure
REQ-032 Package lc3_pkg SHALL hold WORD_W=16, the FSM state enum and DEFAULT_ACK_TIMEOUT=16.
REQ-033 The handshake FSM and timeout counter SHALL be sub-module lc3_mem_fsm; MAR/MDR and bus drive SHALL stay in lc3_mem_if.

Verification
REQ-034 Read, no wait: LD_MAR with bus_in=x3000, MIO_EN=1, R_W=0, ack next cycle with mem_rdata=x1234 -> mem_addr=x3000, R=1, MDR=x1234, main_bus=x1234 under GateMDR.
REQ-035 Write, 3-cycle wait: MAR=x4000, MDR=xBEEF, R_W=1 -> mem_req held 3 cycles with mem_we=1 and mem_wdata=xBEEF; R=1 the cycle after ack.
REQ-036 Timeout: read with no ack -> after 16 REQ cycles R=1, mem_err=1, MDR=x0000; mem_err stays 1 until rst.
REQ-037 Reset mid-REQ: rst during wait, then a late ack with mem_rdata=xFFFF -> mem_req=0, MDR=0, R=0, state IDLE.
REQ-038 Loads blocked: LD_MAR with bus_in=x5555 during REQ -> mem_addr and MAR unchanged; GateMDR=0 -> main_bus=Z.
REQ-039 MIO_EN held through DONE -> exactly one mem_req burst; R stays 1 until MIO_EN=0.
